// File: rtl/axi4lite2reg_native_if.sv
// AXI4-Lite slave front end for the register native interface.
// One-entry AW/W/AR buffers, read/write arbitration, single outstanding request.
module axi4lite2reg_native_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [1:0]                bresp,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      req_vld,
    input  logic                      ack_vld,
    output logic                      wr_en,
    output logic                      rd_en,
    output logic [ADDR_WIDTH-1:0]     addr,
    output logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH-1:0]     rd_data
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_WAIT = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_BRESP   = 3'd3;
    localparam logic [2:0] S_RRESP   = 3'd4;

    logic [2:0]            state;
    logic                  aw_full, w_full, ar_full;
    logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  last_wr;
    logic                  wr_pend, rd_pend;
    logic                  grant_wr, grant_rd;

    assign awready = !aw_full;
    assign wready  = !w_full;
    assign arready = !ar_full;
    assign rresp   = 2'b00;

    // last_wr=0 means the previous grant was a read, so writes win ties first
    always_comb begin
        wr_pend  = aw_full && w_full;
        rd_pend  = ar_full;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == S_IDLE) begin
            grant_wr = wr_pend && (!rd_pend || !last_wr);
            grant_rd = rd_pend && (!wr_pend || last_wr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            ar_full  <= 1'b0;
            awaddr_q <= '0;
            araddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (awvalid && awready) begin
                awaddr_q <= awaddr;
                aw_full  <= 1'b1;
            end else if (grant_wr) begin
                aw_full  <= 1'b0;
            end
            if (wvalid && wready) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
                w_full  <= 1'b1;
            end else if (grant_wr) begin
                w_full  <= 1'b0;
            end
            if (arvalid && arready) begin
                araddr_q <= araddr;
                ar_full  <= 1'b1;
            end else if (grant_rd) begin
                ar_full  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            last_wr <= 1'b0;
            req_vld <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            addr    <= '0;
            wr_data <= '0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            req_vld <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (grant_wr) begin
                        last_wr <= 1'b1;
                        // partial strobes are refused without a native access
                        if (&wstrb_q) begin
                            req_vld <= 1'b1;
                            wr_en   <= 1'b1;
                            rd_en   <= 1'b0;
                            addr    <= awaddr_q;
                            wr_data <= wdata_q;
                            state   <= S_WR_WAIT;
                        end else begin
                            bvalid  <= 1'b1;
                            bresp   <= 2'b10;
                            state   <= S_BRESP;
                        end
                    end else if (grant_rd) begin
                        last_wr <= 1'b0;
                        req_vld <= 1'b1;
                        wr_en   <= 1'b0;
                        rd_en   <= 1'b1;
                        addr    <= araddr_q;
                        state   <= S_RD_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (ack_vld) begin
                        bvalid <= 1'b1;
                        bresp  <= 2'b00;
                        state  <= S_BRESP;
                    end
                end
                S_RD_WAIT: begin
                    if (ack_vld) begin
                        rdata  <= rd_data;
                        rvalid <= 1'b1;
                        state  <= S_RRESP;
                    end
                end
                S_BRESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_RRESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi4lite2reg_native_if.md
Name: axi4lite2reg_native_if

Overview:
- AXI4-Lite slave front end for the register native interface; feeds req_vld/wr_en/rd_en/addr/wr_data into the native-if-to-APB bridge and consumes its ack_vld/rd_data.
- Buffers the AW, W and AR channels independently.
- Arbitrates reads against writes and issues one native request at a time.
- Returns B/R responses.
- Rejects partial-strobe writes with SLVERR without touching the native interface.

Parameters:
- ADDR_WIDTH, 64, address width on AXI and native sides.
- DATA_WIDTH, 32, data width; must be a multiple of 8; strobe width is DATA_WIDTH/8.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- awvalid  in  1  AXI write address valid
- awready  out  1  AXI write address ready
- awaddr  in  ADDR_WIDTH  write address
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  write strobes
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- bresp  out  2  write response, 2'b00 OKAY / 2'b10 SLVERR
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- araddr  in  ADDR_WIDTH  read address
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response, always 2'b00
- req_vld  out  1  native request, single-cycle pulse
- ack_vld  in  1  native completion, single-cycle
- wr_en  out  1  native write qualifier
- rd_en  out  1  native read qualifier
- addr  out  ADDR_WIDTH  native address
- wr_data  out  DATA_WIDTH  native write data
- rd_data  in  DATA_WIDTH  native read data, valid when ack_vld=1

Behaviour:
- Reset: clk is the clock; rst_n is asynchronous, active-low.
  - State S_IDLE; aw_full/w_full/ar_full cleared.
  - req_vld, wr_en, rd_en, bvalid, rvalid = 0.
  - addr, wr_data, rdata = 0; bresp, rresp = 2'b00; last_grant = read, so write wins the first tie.
- Channel buffers (one entry each):
  - awready = !aw_full, wready = !w_full, arready = !ar_full.
  - A handshake captures addr/data/strb and sets the full flag on the next edge.
  - AW and W are accepted in any order or in the same cycle.
- FSM states: S_IDLE, S_WR_WAIT, S_RD_WAIT, S_BRESP, S_RRESP.
- S_IDLE: wr_pend = aw_full&&w_full; rd_pend = ar_full.
  - Both pending: grant the type opposite to last_grant.
  - One pending: grant it.
  - Neither pending: stay in S_IDLE.
  - The grant updates last_grant and clears the granted full flags on the same edge, so the buffer can re-accept the next cycle.
- Write grant with wstrb all-ones:
  - Next cycle req_vld=1, wr_en=1, rd_en=0, addr=awaddr buffer, wr_data=wdata buffer; state S_WR_WAIT.
- Write grant with any strobe 0:
  - No native request is issued.
  - Next cycle bvalid=1, bresp=2'b10; state S_BRESP.
- Read grant:
  - Next cycle req_vld=1, rd_en=1, wr_en=0, addr=araddr buffer; state S_RD_WAIT.
- req_vld is high for exactly one cycle. wr_en/rd_en/addr/wr_data hold until the next grant.
- S_WR_WAIT on ack_vld: next cycle bvalid=1, bresp=2'b00; state S_BRESP.
- S_RD_WAIT on ack_vld: rd_data registered into rdata; next cycle rvalid=1, rresp=2'b00; state S_RRESP.
- S_BRESP / S_RRESP:
  - Hold valid and payload stable until bready/rready.
  - Valid drops on the edge after the handshake; state returns to S_IDLE.
  - A new grant is possible the following cycle.
- Minimum latency: AW+W handshake at cycle T → req_vld at T+2 → ack at T+3 (zero-wait downstream) → bvalid at T+4.
- One outstanding native transaction at a time; no native timeout.
- ack_vld in S_IDLE, S_BRESP or S_RRESP is ignored.
- Reset asserted mid-transaction: all state is dropped immediately to reset values; no response is produced for the in-flight access.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, wstrb 4'hF, AW and W in the same cycle; ack_vld 3 cycles after req_vld → single req_vld pulse with wr_en=1, addr=0x10, wr_data=0xDEADBEEF; bvalid with bresp 2'b00 one cycle after ack.
- Read addr 0x24; ack_vld with rd_data 0x12345678; rready low for 4 cycles → rvalid and rdata=0x12345678 held stable throughout; rvalid clears the cycle after rready.
- Write with wstrb 4'h3 → no req_vld ever; bvalid with bresp 2'b10; next full-strobe write proceeds normally.
- W arrives 5 cycles before AW → no req_vld until AW accepted; req_vld exactly 2 cycles after the AW handshake.
- Write and read pending simultaneously after reset, repeated 4 times → native order W,R,W,R,…; never two req_vld without an intervening ack_vld.
- Assert rst_n low during S_RD_WAIT, then inject a spurious ack_vld after release → all outputs at reset values; no rvalid, no req_vld; first new read works normally.
